fpu_sqrt_iter: RTL

//  Parametrised iterative square-root datapath for the FPU arithmetic unit (SP and DP builds).

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_sqrt_iter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants, the square-root FSM state encoding and the iteration-count helper.
package fpu_pkg;

  localparam int SP_SIG_W = 24;
  localparam int SP_EXP_W = 8;
  localparam int SP_BIAS  = 127;
  localparam int DP_SIG_W = 53;
  localparam int DP_EXP_W = 11;
  localparam int DP_BIAS  = 1023;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRENORM = 2'd1,
    S_ITER    = 2'd2,
    S_DONE    = 2'd3
  } sqrt_state_e;

  // Cycles needed to retire SIG_W+2 root bits at bpc bits per cycle.
  function automatic int sqrt_iters(input int sig_w, input int bpc);
    return (sig_w + 2 + bpc - 1) / bpc;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns W.
module fpu_lzc #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_sqrt_iter.sv
// Iterative digit-recurrence square root: prenormalise, BITS_PER_CYC root bits per cycle, unrounded result.
// Optional macro FPU_SQRT_FLUSH_EN adds the flush port that aborts an in-flight operation.
module fpu_sqrt_iter
  import fpu_pkg::*;
#(
  parameter int SIG_W        = SP_SIG_W,
  parameter int EXP_W        = SP_EXP_W,
  parameter int BIAS         = SP_BIAS,
  parameter int BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic             is_subnormal,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SIG_W-1:0] in_sig,
`ifdef FPU_SQRT_FLUSH_EN
  input  logic             flush,
`endif
  output logic             done,
  output logic [SIG_W+2:0] out_sig,
  output logic [EXP_W-1:0] out_exp,
  output sqrt_state_e      dbg_state
);

  // Handshake: an operation transfers on a rising edge where start && ready; done is a
  // single-cycle pulse with no back-pressure, and out_* hold their value until the next done.

  localparam int ITERS = sqrt_iters(SIG_W, BITS_PER_CYC);
  localparam int NB    = ITERS * BITS_PER_CYC;
  localparam int RW    = NB + 2;
  localparam int XW    = 2 * NB;
  localparam int EW    = EXP_W + 2;
  localparam int LZW   = $clog2(SIG_W + 1);
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [NB-1:0] EXTRA_MASK = (NB'(1) << (NB - SIG_W - 2)) - NB'(1);

  sqrt_state_e state, nxt_state;

  logic             flush_i;
`ifdef FPU_SQRT_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  logic [SIG_W-1:0] op_sig;
  logic [EXP_W-1:0] op_exp;
  logic             op_subn;
  logic [XW-1:0]    rad;
  logic [RW-1:0]    rem;
  logic [NB-1:0]    root;
  logic [CW-1:0]    cnt;
  logic [EXP_W-1:0] res_exp;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    ready     = (state == S_IDLE);
    done      = (state == S_DONE) && !flush_i;
    case (state)
      S_IDLE:    if (start) nxt_state = S_PRENORM;
      S_PRENORM: nxt_state = S_ITER;
      S_ITER:    if (cnt == '0) nxt_state = S_DONE;
      S_DONE:    nxt_state = S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
    if (flush_i) nxt_state = S_IDLE;
  end

  assign dbg_state = state;

  // ---------------- prenormalisation ----------------
  logic [LZW-1:0]         lz;
  logic [SIG_W-1:0]       sig_n;
  logic signed [EW-1:0]   e_base, e_unb, e_half;
  logic [XW-1:0]          rad_n;
  logic [EXP_W-1:0]       exp_n;

  fpu_lzc #(.W(SIG_W), .CW(LZW)) u_lzc (
    .value (op_sig),
    .count (lz)
  );

  always_comb begin
    sig_n  = op_sig << lz;
    e_base = op_subn ? EW'(1) : EW'(op_exp);
    e_unb  = e_base - EW'(BIAS) - EW'(lz);
    e_half = e_unb >>> 1;
    exp_n  = EXP_W'(e_half + EW'(BIAS));
    // Odd unbiased exponent folds one factor of two into the radicand, giving [2,4).
    rad_n  = e_unb[0] ? (XW'(sig_n) << (XW - SIG_W)) : (XW'(sig_n) << (XW - SIG_W - 1));
  end

  // ---------------- recurrence stages ----------------
  logic [RW-1:0] st_rem [0:BITS_PER_CYC];
  logic [NB-1:0] st_q   [0:BITS_PER_CYC];
  logic [XW-1:0] st_x   [0:BITS_PER_CYC];

  assign st_rem[0] = rem;
  assign st_q[0]   = root;
  assign st_x[0]   = rad;

  for (genvar g = 0; g < BITS_PER_CYC; g++) begin : g_stage
    logic [RW-1:0] sh;
    logic [RW-1:0] trial;
    assign sh    = {st_rem[g][RW-3:0], st_x[g][XW-1 -: 2]};
    // Non-restoring step: add back when the running remainder is negative.
    assign trial = st_rem[g][RW-1] ? (sh + {st_q[g], 2'b11}) : (sh - {st_q[g], 2'b01});
    assign st_rem[g+1] = trial;
    assign st_q[g+1]   = {st_q[g][NB-2:0], ~trial[RW-1]};
    assign st_x[g+1]   = {st_x[g][XW-3:0], 2'b00};
  end

  logic [NB-1:0] q_end;
  logic [RW-1:0] rem_end, rem_fix;
  logic          sticky;

  always_comb begin
    q_end   = st_q[BITS_PER_CYC];
    rem_end = st_rem[BITS_PER_CYC];
    rem_fix = rem_end[RW-1] ? (rem_end + RW'({q_end, 1'b1})) : rem_end;
    sticky  = (|rem_fix) | (|(q_end & EXTRA_MASK));
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_sig  <= '0;
      op_exp  <= '0;
      op_subn <= 1'b0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      cnt     <= '0;
      res_exp <= '0;
      out_sig <= '0;
      out_exp <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush_i) begin
            op_sig  <= in_sig;
            op_exp  <= in_exp;
            op_subn <= is_subnormal;
          end
        end
        S_PRENORM: begin
          rad     <= rad_n;
          rem     <= '0;
          root    <= '0;
          cnt     <= CW'(ITERS - 1);
          res_exp <= (op_sig == '0) ? '0 : exp_n;
        end
        S_ITER: begin
          rem  <= st_rem[BITS_PER_CYC];
          root <= st_q[BITS_PER_CYC];
          rad  <= st_x[BITS_PER_CYC];
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!flush_i) begin
            out_sig <= {q_end[NB-1 -: SIG_W+2], sticky};
            out_exp <= res_exp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
